// File: rtl/alu_status_handler.sv
// ALU status handler: tracks architectural Z/V/C/N flags and a saturating overflow counter,
// and raises a precise exception (cause + EPC) through a 4-phase req/ack handshake.
module alu_status_handler #(
  parameter int unsigned CNT_W      = 8,
  parameter logic [4:0]  CAUSE_OV   = 5'd12,
  parameter logic [4:0]  CAUSE_ADEL = 5'd4,
  parameter logic [4:0]  CAUSE_ADES = 5'd5,
  parameter logic [4:0]  CAUSE_DIVZ = 5'd15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             status_valid_i,
  input  logic [7:0]       alu_status_i,
  input  logic             trap_ovf_en_i,
  input  logic             mem_access_i,
  input  logic             mem_write_i,
  input  logic             is_div_i,
  input  logic [31:0]      pc_i,
  input  logic             exc_ack_i,
  output logic             exc_req_o,
  output logic [4:0]       exc_cause_o,
  output logic [31:0]      epc_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] ovf_count_o,
  output logic             stall_o
);

  typedef enum logic [1:0] {StIdle, StPending, StRelease} state_e;

  state_e             state_q, state_d;
  logic               exc_req_q, exc_req_d;
  logic               stall_q, stall_d;
  logic [4:0]         cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;
  logic [3:0]         flags_q, flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic addr_flt, divz_flt, ovf_flt, any_flt;
  logic [4:0] flt_cause;

  // Reserved status bits carry no meaning here.
  logic unused_rsvd;
  assign unused_rsvd = ^alu_status_i[1:0];

  // Fault qualification and priority: address > divide-by-zero > overflow.
  always_comb begin
    addr_flt  = alu_status_i[3] & mem_access_i;
    divz_flt  = alu_status_i[2] & is_div_i;
    ovf_flt   = alu_status_i[6] & trap_ovf_en_i;
    any_flt   = addr_flt | divz_flt | ovf_flt;
    flt_cause = CAUSE_OV;
    if (addr_flt) begin
      flt_cause = mem_write_i ? CAUSE_ADES : CAUSE_ADEL;
    end else if (divz_flt) begin
      flt_cause = CAUSE_DIVZ;
    end
  end

  // Next-state for handshake FSM and all registered outputs.
  always_comb begin
    state_d   = state_q;
    exc_req_d = exc_req_q;
    stall_d   = stall_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (status_valid_i) begin
          // Overflow events are counted even when they trap.
          if (alu_status_i[6] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (any_flt) begin
            state_d   = StPending;
            exc_req_d = 1'b1;
            stall_d   = 1'b1;
            cause_d   = flt_cause;
            epc_d     = pc_i;
          end else begin
            flags_d = alu_status_i[7:4];
          end
        end
      end
      StPending: begin
        if (exc_ack_i) begin
          state_d   = StRelease;
          exc_req_d = 1'b0;
        end
      end
      StRelease: begin
        // Stay stalled until the ack drops, completing the 4-phase handshake.
        if (!exc_ack_i) begin
          state_d = StIdle;
          stall_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        exc_req_d = 1'b0;
        stall_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous abort on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      exc_req_q <= 1'b0;
      stall_q   <= 1'b0;
      cause_q   <= 5'd0;
      epc_q     <= 32'd0;
      flags_q   <= 4'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      exc_req_q <= exc_req_d;
      stall_q   <= stall_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
    end
  end

  assign exc_req_o   = exc_req_q;
  assign stall_o     = stall_q;
  assign exc_cause_o = cause_q;
  assign epc_o       = epc_q;
  assign flags_o     = flags_q;
  assign ovf_count_o = cnt_q;

endmodule
